// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/memory types for the memory arbiter
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Request classes, listed in default priority order
  typedef enum logic [1:0] {
    DWR = 2'd0,
    DRD = 2'd1,
    IRD = 2'd2
  } arb_kind_t;

endpackage

// File: rtl/cache_control_if.sv
// rtl/cache_control_if.sv - cache/memory control bundle between cores, arbiter and RAM
interface cache_control_if #(
  parameter int CPUS = 2
);

  logic [CPUS-1:0]                  iREN;
  logic [CPUS-1:0]                  dREN;
  logic [CPUS-1:0]                  dWEN;
  cpu_types_pkg::word_t [CPUS-1:0]  iaddr;
  cpu_types_pkg::word_t [CPUS-1:0]  daddr;
  cpu_types_pkg::word_t [CPUS-1:0]  dstore;
  logic [CPUS-1:0]                  iwait;
  logic [CPUS-1:0]                  dwait;
  cpu_types_pkg::word_t [CPUS-1:0]  iload;
  cpu_types_pkg::word_t [CPUS-1:0]  dload;
  logic                             ramREN;
  logic                             ramWEN;
  cpu_types_pkg::word_t             ramaddr;
  cpu_types_pkg::word_t             ramstore;
  cpu_types_pkg::word_t             ramload;
  cpu_types_pkg::ramstate_t         ramstate;

  modport cc (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin priority picker: first request at or after ptr wins
module rr_pick #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic         valid_o
);

  logic [W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = W'((int'(ptr_i) + k) % N);
      if (gnt_o == '0 && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - multi-core RAM arbiter: DWR > DRD > IRD with ifetch anti-starvation
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS          = 2,
  parameter int IFETCH_STARVE = 15
) (
  input logic         CLK,
  input logic         nRST,
  cache_control_if.cc ccif
);

  localparam int IDXW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int SW   = (IFETCH_STARVE > 0) ? $clog2(IFETCH_STARVE + 1) : 1;
  localparam logic [SW-1:0]   STARVE_MAX = SW'(IFETCH_STARVE);
  localparam logic [IDXW-1:0] LAST_CPU   = IDXW'(CPUS - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IDXW-1:0] gnt_cpu_q, gnt_cpu_d;
  arb_kind_t       gnt_kind_q, gnt_kind_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]   starve_cnt_q, starve_cnt_d;

  logic [CPUS-1:0] dwr_req, drd_req, ird_req;
  logic [CPUS-1:0] dwr_gnt, drd_gnt, ird_gnt;
  logic            dwr_vld, drd_vld, ird_vld;
  logic [CPUS-1:0] win_oh;
  logic [IDXW-1:0] win_idx;
  arb_kind_t       win_kind;
  logic            win_req, granted, complete, abort;

  // A core asserting both dWEN and dREN is treated purely as a writer
  assign dwr_req = ccif.dWEN;
  assign drd_req = ccif.dREN & ~ccif.dWEN;
  assign ird_req = ccif.iREN;

  rr_pick #(.N(CPUS), .W(IDXW)) u_pick_dwr (
    .req_i(dwr_req), .ptr_i(rr_ptr_q), .gnt_o(dwr_gnt), .valid_o(dwr_vld)
  );
  rr_pick #(.N(CPUS), .W(IDXW)) u_pick_drd (
    .req_i(drd_req), .ptr_i(rr_ptr_q), .gnt_o(drd_gnt), .valid_o(drd_vld)
  );
  rr_pick #(.N(CPUS), .W(IDXW)) u_pick_ird (
    .req_i(ird_req), .ptr_i(rr_ptr_q), .gnt_o(ird_gnt), .valid_o(ird_vld)
  );

  always_comb begin
    win_kind = IRD;
    win_oh   = ird_gnt;
    if (!(starve_cnt_q == STARVE_MAX && ird_vld)) begin
      if (dwr_vld) begin
        win_kind = DWR;
        win_oh   = dwr_gnt;
      end else if (drd_vld) begin
        win_kind = DRD;
        win_oh   = drd_gnt;
      end
    end
    win_idx = '0;
    for (int i = 0; i < CPUS; i++) begin
      if (win_oh[i]) win_idx = IDXW'(i);
    end
  end

  always_comb begin
    case (gnt_kind_q)
      DWR:     win_req = ccif.dWEN[gnt_cpu_q];
      DRD:     win_req = ccif.dREN[gnt_cpu_q];
      default: win_req = ccif.iREN[gnt_cpu_q];
    endcase
  end

  assign granted  = (state_q == GRANT);
  assign abort    = granted && !win_req;
  assign complete = granted && win_req && (ccif.ramstate == ACCESS);

  // RAM command comes only from the registered winner; zero while idle
  always_comb begin
    ccif.ramREN   = 1'b0;
    ccif.ramWEN   = 1'b0;
    ccif.ramaddr  = '0;
    ccif.ramstore = '0;
    if (granted) begin
      case (gnt_kind_q)
        DWR: begin
          ccif.ramWEN   = 1'b1;
          ccif.ramaddr  = ccif.daddr[gnt_cpu_q];
          ccif.ramstore = ccif.dstore[gnt_cpu_q];
        end
        DRD: begin
          ccif.ramREN  = 1'b1;
          ccif.ramaddr = ccif.daddr[gnt_cpu_q];
        end
        default: begin
          ccif.ramREN  = 1'b1;
          ccif.ramaddr = ccif.iaddr[gnt_cpu_q];
        end
      endcase
    end
  end

  always_comb begin
    ccif.iwait = '1;
    ccif.dwait = '1;
    if (complete) begin
      if (gnt_kind_q == IRD) ccif.iwait[gnt_cpu_q] = 1'b0;
      else                   ccif.dwait[gnt_cpu_q] = 1'b0;
    end
  end

  assign ccif.iload = {CPUS{ccif.ramload}};
  assign ccif.dload = {CPUS{ccif.ramload}};

  always_comb begin
    state_d      = state_q;
    gnt_cpu_d    = gnt_cpu_q;
    gnt_kind_d   = gnt_kind_q;
    rr_ptr_d     = rr_ptr_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      IDLE: begin
        if (dwr_vld || drd_vld || ird_vld) begin
          state_d    = GRANT;
          gnt_cpu_d  = win_idx;
          gnt_kind_d = win_kind;
        end
      end
      default: begin
        if (abort) begin
          state_d = IDLE;
        end else if (complete) begin
          state_d  = IDLE;
          rr_ptr_d = (gnt_cpu_q == LAST_CPU) ? '0 : gnt_cpu_q + IDXW'(1);
        end
      end
    endcase
    // Count data completions that overtook a pending instruction fetch
    if (!(|ccif.iREN)) begin
      starve_cnt_d = '0;
    end else if (complete && gnt_kind_q == IRD) begin
      starve_cnt_d = '0;
    end else if (complete && starve_cnt_q != STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      gnt_cpu_q    <= '0;
      gnt_kind_q   <= IRD;
      rr_ptr_q     <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      gnt_cpu_q    <= gnt_cpu_d;
      gnt_kind_q   <= gnt_kind_d;
      rr_ptr_q     <= rr_ptr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - bench for memory_arbiter: reference model, directed and random traffic
module tb_memory_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS   = 4;
  localparam int STARVE = 3;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  cache_control_if #(.CPUS(CPUS)) ccif ();

  memory_arbiter #(.CPUS(CPUS), .IFETCH_STARVE(STARVE)) dut (
    .CLK (clk),
    .nRST(nrst),
    .ccif(ccif)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: grant in flight (busy/cpu/kind 1=DWR 2=DRD 3=IRD), rr pointer, starvation count
  bit m_busy   = 1'b0;
  int m_cpu    = 0;
  int m_kind   = 3;
  int m_rr     = 0;
  int m_starve = 0;

  int    done_q[$];
  word_t done_addr[$];

  int busy_n   = 2;
  bit rnd_mode = 1'b0;
  int ram_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int first_from(input logic [CPUS-1:0] v, input int start);
    for (int k = 0; k < CPUS; k++) begin
      if (v[(start + k) % CPUS]) return (start + k) % CPUS;
    end
    return 0;
  endfunction

  // Per-cycle compare against the model, then advance the model across the next edge
  initial forever begin
    logic            e_ren, e_wen;
    word_t           e_addr, e_store;
    logic [CPUS-1:0] e_iw, e_dw, w, r, f;
    bit              req_still, done;
    @(negedge clk);
    if (!nrst) begin
      m_busy = 1'b0; m_cpu = 0; m_kind = 3; m_rr = 0; m_starve = 0;
    end
    e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
    e_iw = '1; e_dw = '1;
    req_still = 1'b0;
    if (m_busy) begin
      case (m_kind)
        1: begin e_wen = 1'b1; e_addr = ccif.daddr[m_cpu]; e_store = ccif.dstore[m_cpu];
                 req_still = ccif.dWEN[m_cpu]; end
        2: begin e_ren = 1'b1; e_addr = ccif.daddr[m_cpu]; req_still = ccif.dREN[m_cpu]; end
        default: begin e_ren = 1'b1; e_addr = ccif.iaddr[m_cpu]; req_still = ccif.iREN[m_cpu]; end
      endcase
    end
    done = m_busy && req_still && (ccif.ramstate == ACCESS);
    if (done) begin
      if (m_kind == 3) e_iw[m_cpu] = 1'b0;
      else             e_dw[m_cpu] = 1'b0;
    end
    check("ramREN", ccif.ramREN, e_ren);
    check("ramWEN", ccif.ramWEN, e_wen);
    check("ramaddr", ccif.ramaddr, e_addr);
    check("ramstore", ccif.ramstore, e_store);
    check("iwait", ccif.iwait, e_iw);
    check("dwait", ccif.dwait, e_dw);
    for (int i = 0; i < CPUS; i++) begin
      check("iload", ccif.iload[i], ccif.ramload);
      check("dload", ccif.dload[i], ccif.ramload);
      if (ccif.dwait[i] === 1'b0) begin
        done_q.push_back((ccif.ramWEN ? 10 : 20) + i);
        done_addr.push_back(ccif.ramaddr);
      end
      if (ccif.iwait[i] === 1'b0) begin
        done_q.push_back(30 + i);
        done_addr.push_back(ccif.ramaddr);
      end
    end
    if (nrst) begin
      w = ccif.dWEN; r = ccif.dREN & ~ccif.dWEN; f = ccif.iREN;
      if (!m_busy) begin
        if (f != 0 && m_starve == STARVE) begin m_busy = 1; m_kind = 3; m_cpu = first_from(f, m_rr); end
        else if (w != 0) begin m_busy = 1; m_kind = 1; m_cpu = first_from(w, m_rr); end
        else if (r != 0) begin m_busy = 1; m_kind = 2; m_cpu = first_from(r, m_rr); end
        else if (f != 0) begin m_busy = 1; m_kind = 3; m_cpu = first_from(f, m_rr); end
      end else if (!req_still) begin
        m_busy = 1'b0;
      end else if (done) begin
        m_busy = 1'b0;
        m_rr   = (m_cpu + 1) % CPUS;
      end
      if (f == 0)          m_starve = 0;
      else if (done)       m_starve = (m_kind == 3) ? 0 : ((m_starve < STARVE) ? m_starve + 1 : STARVE);
    end
  end

  // RAM responder: BUSY for busy_n cycles then ACCESS, or random status in random mode
  initial forever begin
    @(posedge clk);
    #2;
    ccif.ramload = $urandom;
    if (rnd_mode) begin
      ccif.ramstate = ramstate_t'($urandom_range(0, 3));
    end else if (ccif.ramREN || ccif.ramWEN) begin
      ccif.ramstate = (ram_cnt >= busy_n) ? ACCESS : BUSY;
      ram_cnt++;
    end else begin
      ccif.ramstate = FREE;
      ram_cnt = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    ccif.iREN = '0; ccif.dREN = '0; ccif.dWEN = '0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int cnt = 0;
    while (done_q.size() < n && cnt < budget) begin
      @(posedge clk);
      cnt++;
    end
    #1;
    check("wait_done_in_budget", done_q.size() >= n, 1'b1);
  endtask

  initial begin
    int cnt;
    clear_reqs();
    for (int i = 0; i < CPUS; i++) begin
      ccif.iaddr[i]  = 32'h2000 + 32'(16 * i);
      ccif.daddr[i]  = 32'h1000 + 32'(16 * i);
      ccif.dstore[i] = 32'hD000_0000 + 32'(i);
    end
    ccif.ramload  = '0;
    ccif.ramstate = FREE;

    // Reset held with every request asserted
    nrst = 1'b0;
    ccif.iREN = '1; ccif.dREN = '1; ccif.dWEN = '1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ramREN", ccif.ramREN, 1'b0);
    check("rst_ramWEN", ccif.ramWEN, 1'b0);
    check("rst_ramaddr", ccif.ramaddr, 32'h0);
    check("rst_iwait", ccif.iwait, 4'hF);
    check("rst_dwait", ccif.dwait, 4'hF);
    @(posedge clk); #1;
    clear_reqs();
    nrst = 1'b1;
    tick(2);

    // Two writers held: grants alternate 0,1,0
    done_q.delete(); done_addr.delete();
    busy_n = 2;
    ccif.dWEN = 4'b0011;
    wait_done(3, 60);
    clear_reqs();
    check("alt_g0", done_q[0], 10);
    check("alt_g1", done_q[1], 11);
    check("alt_g2", done_q[2], 10);
    tick(2);

    // Data read on CPU1 beats fetch on CPU0
    done_q.delete(); done_addr.delete();
    ccif.dREN = 4'b0010; ccif.iREN = 4'b0001;
    wait_done(1, 40);
    ccif.dREN = '0;
    wait_done(2, 40);
    clear_reqs();
    check("cls_g0", done_q[0], 21);
    check("cls_g1", done_q[1], 30);
    check("cls_a0", done_addr[0], 32'h1010);
    check("cls_a1", done_addr[1], 32'h2000);
    tick(2);

    // Starvation: fetch wins after exactly 3 data completions
    done_q.delete(); done_addr.delete();
    ccif.dWEN = 4'b0011; ccif.iREN = 4'b0001;
    wait_done(4, 80);
    clear_reqs();
    check("stv_g0", done_q[0], 11);
    check("stv_g1", done_q[1], 10);
    check("stv_g2", done_q[2], 11);
    check("stv_g3", done_q[3], 30);
    tick(2);

    // Abort: winner drops its read while RAM is busy
    done_q.delete(); done_addr.delete();
    busy_n = 6;
    ccif.dREN = 4'b0010;
    cnt = 0;
    while (!ccif.ramREN && cnt < 20) begin @(posedge clk); #1; cnt++; end
    check("abort_granted", ccif.ramREN, 1'b1);
    tick(2);
    ccif.dREN = '0;
    tick(3);
    check("abort_no_pulse", done_q.size(), 0);
    check("abort_idle", ccif.ramREN, 1'b0);
    busy_n = 2;
    ccif.dREN = 4'b0011;
    wait_done(2, 40);
    clear_reqs();
    check("abort_rr_g0", done_q[0], 21);
    check("abort_rr_g1", done_q[1], 20);
    tick(2);

    // Move pointer to 2, then all fetches: 2,3,0,1
    done_q.delete(); done_addr.delete();
    ccif.iREN = 4'b0010;
    wait_done(1, 40);
    clear_reqs();
    check("rr_setup", done_q[0], 31);
    tick(2);
    done_q.delete(); done_addr.delete();
    ccif.iREN = 4'b1111;
    wait_done(4, 80);
    clear_reqs();
    check("rr4_g0", done_q[0], 32);
    check("rr4_g1", done_q[1], 33);
    check("rr4_g2", done_q[2], 30);
    check("rr4_g3", done_q[3], 31);
    tick(2);

    // Random traffic with random RAM status and occasional resets
    rnd_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < CPUS; i++) begin
        if ($urandom_range(0, 7) == 0) ccif.iREN[i] = ~ccif.iREN[i];
        if ($urandom_range(0, 7) == 0) ccif.dREN[i] = ~ccif.dREN[i];
        if ($urandom_range(0, 9) == 0) ccif.dWEN[i] = ~ccif.dWEN[i];
        if ($urandom_range(0, 3) == 0) ccif.daddr[i]  = $urandom;
        if ($urandom_range(0, 3) == 0) ccif.iaddr[i]  = $urandom;
        if ($urandom_range(0, 3) == 0) ccif.dstore[i] = $urandom;
      end
      nrst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    nrst = 1'b1;
    rnd_mode = 1'b0;
    clear_reqs();
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter CPUS, default 2, number of requesting cores; legal range 1..8.
REQ-002 Parameter IFETCH_STARVE, default 15, maximum consecutive data grants allowed while any instruction request is pending.
REQ-003 CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 ccif  modport cc of cache_control_if, sized by CPUS; the remaining REQ-006..017 are its fields.
REQ-006 ccif.iREN  in  CPUS  instruction read request, one bit per core.
REQ-007 ccif.dREN  in  CPUS  data read request, one bit per core.
REQ-008 ccif.dWEN  in  CPUS  data write request, one bit per core.
REQ-009 ccif.iaddr  in  CPUS x word_t  instruction address per core.
REQ-010 ccif.daddr  in  CPUS x word_t  data address per core.
REQ-011 ccif.dstore  in  CPUS x word_t  write data per core.
REQ-012 ccif.iwait  out  CPUS  instruction wait; low means done.
REQ-013 ccif.dwait  out  CPUS  data wait; low means done.
REQ-014 ccif.iload  out  CPUS x word_t  instruction read data.
REQ-015 ccif.dload  out  CPUS x word_t  data read data.
REQ-016 ccif.ramREN, ramWEN, ramaddr, ramstore  out  1/1/word_t/word_t  RAM command.
REQ-017 ccif.ramload, ramstate  in  word_t / ramstate_t  RAM read data and status (FREE, BUSY, ACCESS, ERROR).

Function
REQ-018 FSM states: IDLE, GRANT; the grant is held in registers gnt_cpu (index) and gnt_kind (DWR, DRD, IRD).
REQ-019 IDLE, any request pending: arbitrate combinationally, register the winner, go to GRANT on the next edge.
- One-cycle arbitration bubble.
- ram outputs are zero while in IDLE.
REQ-020 Class priority is DWR > DRD > IRD, except when starve_cnt reaches IFETCH_STARVE with an IRD pending; then IRD wins.
REQ-021 Within a class, round-robin starting at rr_ptr.
- rr_ptr is a single shared pointer; on every completion it becomes (gnt_cpu+1) mod CPUS.
REQ-022 GRANT drives the RAM from the registered winner only.
- DWR: ramWEN=1, ramaddr=daddr, ramstore=dstore.
- DRD: ramREN=1, ramaddr=daddr.
- IRD: ramREN=1, ramaddr=iaddr.
REQ-023 Completion: in GRANT with ramstate==ACCESS, drive the winner's wait low combinationally in that same cycle, then return to IDLE on the next edge.
REQ-024 ramstate BUSY, FREE or ERROR in GRANT: hold the grant and all RAM outputs unchanged; waits stay high.
REQ-025 Abort: if the winner's request bit drops while in GRANT, return to IDLE next edge with no wait pulse and no rr_ptr update.
REQ-026 All waits are 1 except as granted by REQ-023; non-winners never see a wait pulse.
REQ-027 iload[i] and dload[i] equal ramload for every i at all times.
REQ-028 starve_cnt increments on each DWR/DRD completion while any iREN is high, and clears on IRD completion or when no iREN is high.
- Saturates at IFETCH_STARVE.
- Width is clog2(IFETCH_STARVE+1).
REQ-029 Simultaneous dWEN and dREN from one core: treat as DWR.
REQ-030 Requests asserted during GRANT wait; arbitration happens only in IDLE.

Reset
REQ-031 nRST low asynchronously forces state=IDLE, gnt_cpu=0, gnt_kind=IRD, rr_ptr=0 and starve_cnt=0.
- Consequently ramREN=ramWEN=0, ramaddr=ramstore=0, and all iwait/dwait are 1.
REQ-032 Reset mid-GRANT abandons the transfer; no wait pulse is issued.

Structure
REQ-033 ramstate_t, word_t and the arbiter kind enum (DWR, DRD, IRD) belong in cpu_types_pkg.
REQ-034 One sub-module, rr_pick: a parametrised CPUS-wide round-robin priority picker (request vector and pointer in; one-hot grant and valid out), instantiated once per class.

Verification
REQ-035 Reset: hold nRST low with all requests high -> ramREN=ramWEN=0, all waits 1.
REQ-036 CPUS=2, dWEN[0]=dWEN[1]=1 held, RAM ACCESS after 2 BUSY cycles -> grants alternate 0,1,0 and each dwait pulses low for exactly 1 cycle.
REQ-037 dREN[1] with iREN[0] both pending -> CPU1 data served first, then CPU0 fetch at iaddr[0].
REQ-038 IFETCH_STARVE=3, continuous dWEN from both cores plus iREN[0] -> IRD is granted after exactly 3 data completions.
REQ-039 Winner drops dREN during BUSY -> FSM returns to IDLE, no dwait pulse, rr_ptr unchanged.
REQ-040 CPUS=4, all iREN high, rr_ptr=2 -> service order is 2,3,0,1.
